// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB write side, the ID read ports and the debug/commit observers.
interface wb_regfile_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
);
  logic             rf_we_i;
  logic [AW-1:0]    wR_i;
  logic [DW-1:0]    wD_i;
  logic [AW-1:0]    rR1_i;
  logic [AW-1:0]    rR2_i;
  logic [DW-1:0]    rD1_o;
  logic [DW-1:0]    rD2_o;
  logic [AW-1:0]    dbg_addr_i;
  logic [DW-1:0]    dbg_data_o;
  logic [CNT_W-1:0] wb_cnt_o;

  modport master (
    output rf_we_i, wR_i, wD_i, rR1_i, rR2_i, dbg_addr_i,
    input  rD1_o, rD2_o, dbg_data_o, wb_cnt_o
  );

  modport slave (
    input  rf_we_i, wR_i, wD_i, rR1_i, rR2_i, dbg_addr_i,
    output rD1_o, rD2_o, dbg_data_o, wb_cnt_o
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback register file: x0 hard-wired to zero, write-first bypass on all read ports,
// and a wrapping counter of committed non-x0 writes.
module wb_regfile #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0]    mem_q [NREG];
  logic [DW-1:0]    mem_d [NREG];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             commit;

  assign commit = bus.rf_we_i && (bus.wR_i != '0) && !rst;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (commit) begin
      mem_d[bus.wR_i] = bus.wD_i;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  // Bypass keys off commit so a write held during reset never leaks onto a read port.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] idx);
    logic [DW-1:0] val;
    val = '0;
    if (rst || idx == '0)               val = '0;
    else if (commit && idx == bus.wR_i) val = bus.wD_i;
    else                                val = mem_q[idx];
    return val;
  endfunction

  always_comb begin
    bus.rD1_o      = read_port(bus.rR1_i);
    bus.rD2_o      = read_port(bus.rR2_i);
    bus.dbg_data_o = read_port(bus.dbg_addr_i);
    bus.wb_cnt_o   = cnt_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model plus expectation queue for the read ports.
module tb_wb_regfile;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;

  wb_regfile_if #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]    ref_mem [32];
  logic [CNT_W-1:0] ref_cnt;
  logic [DW-1:0]    sb_q [$];
  logic [DW-1:0]    exp_v;
  logic [DW-1:0]    got_v;

  // Reference read value under the current inputs, including bypass and x0 rules.
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] idx);
    if (rst || idx == 0) return '0;
    if (bus.rf_we_i && bus.wR_i != 0 && bus.wR_i == idx) return bus.wD_i;
    return ref_mem[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_cnt = '0;
    end else if (bus.rf_we_i && bus.wR_i != 0) begin
      ref_mem[bus.wR_i] = bus.wD_i;
      ref_cnt = ref_cnt + 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd5; bus.wD_i = 32'hA5A5A5A5;
    step();
    bus.rR1_i = 5'd5; bus.rR2_i = 5'd5; bus.dbg_addr_i = 5'd5;
    #2;
    checks++;
    if (bus.rD1_o !== '0 || bus.rD2_o !== '0 || bus.dbg_data_o !== '0) begin
      errors++;
      $display("FAIL reset_forced_zero rd1=%h rd2=%h dbg=%h required 0", bus.rD1_o, bus.rD2_o, bus.dbg_data_o);
    end
    step();
    rst = 1'b0;
    bus.rf_we_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rR1_i = 5'(i); bus.rR2_i = 5'(31 - i); bus.dbg_addr_i = 5'(i);
      #1;
      sb_q.push_back('0); sb_q.push_back('0); sb_q.push_back('0);
      exp_v = sb_q.pop_front(); checks++;
      if (bus.rD1_o !== exp_v) begin errors++; $display("FAIL reset_rd1 idx=%0d got=%h required=%h", i, bus.rD1_o, exp_v); end
      exp_v = sb_q.pop_front(); checks++;
      if (bus.rD2_o !== exp_v) begin errors++; $display("FAIL reset_rd2 idx=%0d got=%h required=%h", 31 - i, bus.rD2_o, exp_v); end
      exp_v = sb_q.pop_front(); checks++;
      if (bus.dbg_data_o !== exp_v) begin errors++; $display("FAIL reset_dbg idx=%0d got=%h required=%h", i, bus.dbg_data_o, exp_v); end
    end
    checks++;
    if (bus.wb_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d required=0", bus.wb_cnt_o); end
  endtask

  task automatic test_write_read();
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd5; bus.wD_i = 32'hDEADBEEF;
    sb_q.push_back(32'hDEADBEEF);
    step();
    bus.rf_we_i = 1'b0; bus.rR1_i = 5'd5;
    #1;
    exp_v = sb_q.pop_front(); checks++;
    if (bus.rD1_o !== exp_v) begin errors++; $display("FAIL write_read_x5 got=%h required=%h", bus.rD1_o, exp_v); end
    checks++;
    if (bus.wb_cnt_o !== 4'd1) begin errors++; $display("FAIL write_read_cnt got=%0d required=1", bus.wb_cnt_o); end
  endtask

  task automatic test_bypass();
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd7; bus.wD_i = 32'h12345678;
    bus.rR1_i = 5'd7; bus.rR2_i = 5'd7; bus.dbg_addr_i = 5'd7;
    sb_q.push_back(32'h12345678); sb_q.push_back(32'h12345678); sb_q.push_back(32'h12345678);
    #1;
    exp_v = sb_q.pop_front(); checks++;
    if (bus.rD1_o !== exp_v) begin errors++; $display("FAIL bypass_rd1 got=%h required=%h", bus.rD1_o, exp_v); end
    exp_v = sb_q.pop_front(); checks++;
    if (bus.rD2_o !== exp_v) begin errors++; $display("FAIL bypass_rd2 got=%h required=%h", bus.rD2_o, exp_v); end
    exp_v = sb_q.pop_front(); checks++;
    if (bus.dbg_data_o !== exp_v) begin errors++; $display("FAIL bypass_dbg got=%h required=%h", bus.dbg_data_o, exp_v); end
    step();
    bus.rf_we_i = 1'b0;
    #1;
    checks++;
    if (bus.wb_cnt_o !== 4'd2) begin errors++; $display("FAIL bypass_cnt got=%0d required=2", bus.wb_cnt_o); end
  endtask

  task automatic test_x0();
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd0; bus.wD_i = 32'hFFFFFFFF;
    bus.rR1_i = 5'd0; bus.dbg_addr_i = 5'd0;
    #1;
    checks++;
    if (bus.rD1_o !== '0 || bus.dbg_data_o !== '0) begin
      errors++; $display("FAIL x0_inflight rd1=%h dbg=%h required 0", bus.rD1_o, bus.dbg_data_o);
    end
    step();
    bus.rf_we_i = 1'b0;
    #1;
    checks++;
    if (bus.rD1_o !== '0) begin errors++; $display("FAIL x0_after got=%h required=0", bus.rD1_o); end
    checks++;
    if (bus.wb_cnt_o !== 4'd2) begin errors++; $display("FAIL x0_cnt got=%0d required=2", bus.wb_cnt_o); end
  endtask

  task automatic test_back_to_back();
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd3; bus.wD_i = 32'd1;
    step();
    bus.wD_i = 32'd2;
    sb_q.push_back(32'd2);
    step();
    bus.rf_we_i = 1'b0; bus.rR1_i = 5'd3;
    #1;
    exp_v = sb_q.pop_front(); checks++;
    if (bus.rD1_o !== exp_v) begin errors++; $display("FAIL b2b_x3 got=%h required=%h", bus.rD1_o, exp_v); end
    checks++;
    if (bus.wb_cnt_o !== 4'd4) begin errors++; $display("FAIL b2b_cnt got=%0d required=4", bus.wb_cnt_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bus.rf_we_i    = 1'($urandom_range(0, 1));
      bus.wR_i       = 5'($urandom_range(0, 31));
      bus.wD_i       = $urandom;
      bus.rR1_i      = (n % 4 == 0) ? bus.wR_i : 5'($urandom_range(0, 31));
      bus.rR2_i      = 5'($urandom_range(0, 31));
      bus.dbg_addr_i = (n % 3 == 0) ? bus.wR_i : 5'($urandom_range(0, 31));
      sb_q.push_back(model_rd(bus.rR1_i));
      sb_q.push_back(model_rd(bus.rR2_i));
      sb_q.push_back(model_rd(bus.dbg_addr_i));
      #1;
      for (int p = 0; p < 3; p++) begin
        got_v = (p == 0) ? bus.rD1_o : (p == 1) ? bus.rD2_o : bus.dbg_data_o;
        exp_v = sb_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL random_port%0d cyc=%0d got=%h required=%h", p, n, got_v, exp_v); end
      end
      checks++;
      if (bus.wb_cnt_o !== ref_cnt) begin errors++; $display("FAIL random_cnt cyc=%0d got=%0d required=%0d", n, bus.wb_cnt_o, ref_cnt); end
      step();
    end
    bus.rf_we_i = 1'b0;
  endtask

  task automatic test_counter_wrap();
    bus.rf_we_i = 1'b1;
    while (ref_cnt != 4'hF) begin
      bus.wR_i = 5'($urandom_range(1, 31)); bus.wD_i = $urandom;
      step();
    end
    bus.rf_we_i = 1'b0;
    #1;
    checks++;
    if (bus.wb_cnt_o !== 4'hF) begin errors++; $display("FAIL wrap_pre got=%0d required=15", bus.wb_cnt_o); end
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd12; bus.wD_i = 32'hC0FFEE00;
    step();
    bus.rf_we_i = 1'b0;
    #1;
    checks++;
    if (bus.wb_cnt_o !== 4'h0) begin errors++; $display("FAIL wrap_post got=%0d required=0", bus.wb_cnt_o); end
  endtask

  task automatic test_reset_midstream();
    bus.rf_we_i = 1'b1; bus.wR_i = 5'd9; bus.wD_i = 32'h0BADF00D;
    step();
    rst = 1'b1; bus.wD_i = 32'h55AA55AA;
    step();
    rst = 1'b0; bus.rf_we_i = 1'b0; bus.rR1_i = 5'd9; bus.dbg_addr_i = 5'd9;
    #1;
    checks++;
    if (bus.rD1_o !== '0 || bus.dbg_data_o !== '0) begin
      errors++; $display("FAIL midreset_x9 rd1=%h dbg=%h required 0", bus.rD1_o, bus.dbg_data_o);
    end
    checks++;
    if (bus.wb_cnt_o !== 4'd0) begin errors++; $display("FAIL midreset_cnt got=%0d required=0", bus.wb_cnt_o); end
  endtask

  initial begin
    rst = 1'b1;
    bus.rf_we_i = 1'b0; bus.wR_i = '0; bus.wD_i = '0;
    bus.rR1_i = '0; bus.rR2_i = '0; bus.dbg_addr_i = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_cnt = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_random();
    test_counter_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
